// File: rtl/branch_target_table.sv
// branch_target_table: direct-indexed target table with 1-cycle registered lookup,
// write-to-lookup bypass, single-cycle flush and a saturating miss counter.
module branch_target_table #(
  parameter int KEY_W = 5,
  parameter int POS_W = 12,
  parameter int DEPTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [POS_W-1:0] wr_pos,
  input  logic             flush,
  input  logic             lookup_en,
  input  logic [KEY_W-1:0] key,
  output logic [POS_W-1:0] branch_pos,
  output logic             hit,
  output logic             rsp_valid,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int N = 1 << KEY_W;
  localparam logic [KEY_W:0] DEPTH_V = DEPTH[KEY_W:0];
  // Arrays span the full key space so any key indexes safely; entries at or
  // above DEPTH are never written, so their valid bits stay zero.
  logic [POS_W-1:0] mem [N];
  logic [N-1:0]     valid;
  logic             wr_ok, key_ok, byp, lk_hit;
  logic [POS_W-1:0] lk_pos;
  always_comb begin
    wr_ok  = wr_en && ({1'b0, wr_key} < DEPTH_V);
    key_ok = {1'b0, key} < DEPTH_V;
    byp    = wr_ok && key_ok && (wr_key == key);
    lk_hit = byp || (key_ok && valid[key]);
    lk_pos = byp ? wr_pos : (lk_hit ? mem[key] : '0);
  end
  always_ff @(posedge clk)
    if (!reset && wr_ok) mem[wr_key] <= wr_pos;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      branch_pos <= '0;
      hit        <= 1'b0;
      rsp_valid  <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      if (flush) valid <= '0;
      if (wr_ok) valid[wr_key] <= 1'b1;
      rsp_valid <= lookup_en;
      if (lookup_en) begin
        hit        <= lk_hit;
        branch_pos <= lk_pos;
        if (!lk_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_table.sv
// tb_branch_target_table: directed checks of lookup, bypass, flush, saturation and reset.
module tb_branch_target_table;
  logic        clk = 0;
  logic        reset = 0, wr_en = 0, flush = 0, lookup_en = 0;
  logic [4:0]  wr_key = 0, key = 0;
  logic [11:0] wr_pos = 0;
  logic [11:0] branch_pos;
  logic        hit, rsp_valid;
  logic [2:0]  miss_cnt;
  int errors = 0, checks = 0;

  branch_target_table #(.KEY_W(5), .POS_W(12), .DEPTH(16), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_key(wr_key), .wr_pos(wr_pos),
    .flush(flush), .lookup_en(lookup_en), .key(key),
    .branch_pos(branch_pos), .hit(hit), .rsp_valid(rsp_valid), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rsp(input string tag, input logic v, input logic h, input int p, input int m);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, ".hit"}, 32'(hit), 32'(h));
    chk({tag, ".branch_pos"}, 32'(branch_pos), p);
    chk({tag, ".miss_cnt"}, 32'(miss_cnt), m);
  endtask

  task automatic wr(input int k, input int p);
    wr_en = 1; wr_key = 5'(k); wr_pos = 12'(p);
    cyc();
    wr_en = 0;
  endtask

  task automatic look(input int k);
    lookup_en = 1; key = 5'(k);
    cyc();
    lookup_en = 0;
  endtask

  initial begin
    reset = 1; cyc(); reset = 0;
    rsp("reset", 0, 0, 0, 0);
    look(3);        rsp("miss_k3", 1, 0, 0, 1);
    cyc();          rsp("idle", 0, 0, 0, 1);
    wr(2, 45);
    look(2);        rsp("hit_k2", 1, 1, 45, 1);
    cyc();          rsp("hold", 0, 1, 45, 1);
    look(31);       rsp("miss_k31", 1, 0, 0, 2);
    wr(20, 99);
    look(20);       rsp("oob_wr_k20", 1, 0, 0, 3);
    look(4);        rsp("no_alias_k4", 1, 0, 0, 4);
    wr_en = 1; wr_key = 4; wr_pos = 34; lookup_en = 1; key = 4;
    cyc(); wr_en = 0; lookup_en = 0;
    rsp("bypass_k4", 1, 1, 34, 4);
    wr(15, 4095);
    look(15);       rsp("hit_k15_edge", 1, 1, 4095, 4);
    wr(1, 11);
    wr(5, 55);
    flush = 1; wr_en = 1; wr_key = 5; wr_pos = 38; lookup_en = 1; key = 1;
    cyc(); flush = 0; wr_en = 0; lookup_en = 0;
    rsp("flush_old_k1", 1, 1, 11, 4);
    look(1);        rsp("flushed_k1", 1, 0, 0, 5);
    look(5);        rsp("flush_wr_k5", 1, 1, 38, 5);
    look(4);        rsp("flushed_k4", 1, 0, 0, 6);
    flush = 1; wr_en = 1; wr_key = 6; wr_pos = 66; lookup_en = 1; key = 6;
    cyc(); flush = 0; wr_en = 0; lookup_en = 0;
    rsp("flush_bypass_k6", 1, 1, 66, 6);
    look(6);        rsp("after_k6", 1, 1, 66, 6);
    look(2);        rsp("flushed_k2", 1, 0, 0, 7);
    look(3);        rsp("sat_k3", 1, 0, 0, 7);
    flush = 1; cyc(); flush = 0;
    chk("flush_keeps_cnt", 32'(miss_cnt), 7);
    reset = 1; cyc(); reset = 0;
    rsp("reset2", 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      look(i);
      chk($sformatf("sat_seq%0d", i), 32'(miss_cnt), (i > 7) ? 7 : i);
    end
    wr(7, 77);
    lookup_en = 1; key = 7; wr_en = 1; wr_key = 8; wr_pos = 88; reset = 1;
    cyc(); lookup_en = 0; wr_en = 0; reset = 0;
    rsp("reset_prio", 0, 0, 0, 0);
    look(8);        rsp("reset_blocks_wr", 1, 0, 0, 1);
    look(7);        rsp("reset_clears_k7", 1, 0, 0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
